// File: rtl/hdmi_source_ctrl.sv
// HDMI loopback source select: rx passthrough when the rx timing is locked, else an internal colour-bar pattern.
// Every tx output is registered with 1 cycle latency and there is no backpressure; rx timing is checked continuously.
module hdmi_source_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 4,
  parameter int LOSS_CYCLES  = 840000
) (
  input  logic        pixclk,
  input  logic        rst,
  input  logic [7:0]  rx_red,
  input  logic [7:0]  rx_green,
  input  logic [7:0]  rx_blue,
  input  logic        rx_hsync,
  input  logic        rx_vsync,
  input  logic        rx_vde,
  input  logic [3:0]  rx_cntrl,
  input  logic        force_pattern,
  output logic [7:0]  tx_red,
  output logic [7:0]  tx_green,
  output logic [7:0]  tx_blue,
  output logic        tx_hsync,
  output logic        tx_vsync,
  output logic        tx_vde,
  output logic [3:0]  tx_cntrl,
  output logic        locked,
  output logic        src_is_rx,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_active
);
  localparam int BAR_W = H_ACTIVE / 8;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t state, state_next;

  logic        vs_q, vde_q, vs_rise, vde_rise, run_end, run_bad;
  logic [11:0] run_cnt, last_run, line_cnt;
  logic        bad_flag, frame_good, loss;
  logic [23:0] to_cnt;
  logic [7:0]  good_cnt, good_next;
  logic        locked_next, to_pat, to_rx, src_next;
  logic [11:0] h, v;
  logic        gen_vde, gen_hs, gen_vs;
  logic [2:0]  bar;
  logic [23:0] bar_rgb;

  assign vs_rise    = rx_vsync & ~vs_q;
  assign vde_rise   = rx_vde & ~vde_q;
  assign run_end    = vde_q & ~rx_vde;
  assign run_bad    = run_end && (run_cnt != 12'(H_ACTIVE));
  assign frame_good = ~bad_flag && ~run_bad && (line_cnt == 12'(V_ACTIVE));
  // A vs_rise in the same cycle as the limit keeps the input alive.
  assign loss       = ~vs_rise && (to_cnt >= 24'(LOSS_CYCLES - 1));

  always_ff @(posedge pixclk) begin
    if (rst) begin
      vs_q <= 1'b0; vde_q <= 1'b0;
      run_cnt <= '0; last_run <= '0; line_cnt <= '0; bad_flag <= 1'b0;
      meas_h_active <= '0; meas_v_active <= '0; to_cnt <= '0;
    end else begin
      vs_q  <= rx_vsync;
      vde_q <= rx_vde;
      if (rx_vde)
        run_cnt <= vde_rise ? 12'd1 : (run_cnt == 12'hFFF ? run_cnt : run_cnt + 12'd1);
      if (run_end) last_run <= run_cnt;
      if (vs_rise) begin
        meas_h_active <= run_end ? run_cnt : last_run;
        meas_v_active <= line_cnt;
        line_cnt      <= {11'd0, vde_rise};
        bad_flag      <= 1'b0;
      end else begin
        if (vde_rise && line_cnt != 12'hFFF) line_cnt <= line_cnt + 12'd1;
        if (run_bad) bad_flag <= 1'b1;
      end
      if (vs_rise)                to_cnt <= '0;
      else if (to_cnt != 24'hFFFFFF) to_cnt <= to_cnt + 24'd1;
    end
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      state <= SEARCH; good_cnt <= '0; locked <= 1'b0; src_is_rx <= 1'b0;
    end else begin
      state <= state_next; good_cnt <= good_next; locked <= locked_next; src_is_rx <= src_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    case (state)
      SEARCH: if (vs_rise) begin
        state_next = VERIFY;
        good_next  = '0;
      end
      VERIFY: if (vs_rise) begin
        if (frame_good) begin
          good_next = good_cnt + 8'd1;
          if (good_cnt + 8'd1 == 8'(LOCK_FRAMES)) state_next = LOCKED;
        end else begin
          good_next = '0;
        end
      end else if (loss) begin
        state_next = SEARCH;
      end
      LOCKED: if ((vs_rise && !frame_good) || loss) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  // Switching to rx also requires staying locked, so a bad frame never flips to rx for one cycle.
  always_comb begin
    locked_next = (state_next == LOCKED);
    to_pat      = (!locked_next || force_pattern) && src_is_rx;
    to_rx       = vs_rise && (state == LOCKED) && locked_next && !force_pattern && !src_is_rx;
    src_next    = src_is_rx;
    if (to_pat)     src_next = 1'b0;
    else if (to_rx) src_next = 1'b1;
  end

  always_ff @(posedge pixclk) begin
    if (rst || to_pat) begin
      h <= '0; v <= '0;
    end else if (h == 12'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == 12'(V_TOTAL - 1)) ? 12'd0 : v + 12'd1;
    end else begin
      h <= h + 12'd1;
    end
  end

  always_comb begin
    gen_vde = (h < 12'(H_ACTIVE)) && (v < 12'(V_ACTIVE));
    gen_hs  = (h >= 12'(H_SYNC_START)) && (h < 12'(H_SYNC_END));
    gen_vs  = (v >= 12'(V_SYNC_START)) && (v < 12'(V_SYNC_END));
    bar = 3'd7;
    for (int i = 7; i >= 0; i--)
      if (h < 12'((i + 1) * BAR_W)) bar = 3'(i);
    bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      tx_red <= '0; tx_green <= '0; tx_blue <= '0;
      tx_hsync <= 1'b0; tx_vsync <= 1'b0; tx_vde <= 1'b0; tx_cntrl <= '0;
    end else if (src_is_rx) begin
      tx_red <= rx_red; tx_green <= rx_green; tx_blue <= rx_blue;
      tx_hsync <= rx_hsync; tx_vsync <= rx_vsync; tx_vde <= rx_vde; tx_cntrl <= rx_cntrl;
    end else begin
      tx_red   <= gen_vde ? bar_rgb[23:16] : 8'd0;
      tx_green <= gen_vde ? bar_rgb[15:8]  : 8'd0;
      tx_blue  <= gen_vde ? bar_rgb[7:0]   : 8'd0;
      tx_hsync <= gen_hs; tx_vsync <= gen_vs; tx_vde <= gen_vde; tx_cntrl <= '0;
    end
  end
endmodule

// File: tb/tb_hdmi_source_ctrl.sv
// Directed bench for hdmi_source_ctrl using a shrunken 16x6 (24x10 total) timing.
module tb_hdmi_source_ctrl;
  localparam int HA = 16, HSS = 18, HSE = 20, HT = 24;
  localparam int VA = 6, VSS = 7, VSE = 9, VT = 10;
  localparam int LF = 4, LOSS = 600;

  logic       pixclk = 1'b0;
  logic       rst;
  logic [7:0] rx_red, rx_green, rx_blue;
  logic       rx_hsync, rx_vsync, rx_vde;
  logic [3:0] rx_cntrl;
  logic       force_pattern;
  logic [7:0] tx_red, tx_green, tx_blue;
  logic       tx_hsync, tx_vsync, tx_vde;
  logic [3:0] tx_cntrl;
  logic       locked, src_is_rx;
  logic [11:0] meas_h_active, meas_v_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  hdmi_source_ctrl #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .LOCK_FRAMES(LF), .LOSS_CYCLES(LOSS)
  ) dut (
    .pixclk(pixclk), .rst(rst),
    .rx_red(rx_red), .rx_green(rx_green), .rx_blue(rx_blue),
    .rx_hsync(rx_hsync), .rx_vsync(rx_vsync), .rx_vde(rx_vde), .rx_cntrl(rx_cntrl),
    .force_pattern(force_pattern),
    .tx_red(tx_red), .tx_green(tx_green), .tx_blue(tx_blue),
    .tx_hsync(tx_hsync), .tx_vsync(tx_vsync), .tx_vde(tx_vde), .tx_cntrl(tx_cntrl),
    .locked(locked), .src_is_rx(src_is_rx),
    .meas_h_active(meas_h_active), .meas_v_active(meas_v_active)
  );

  always #20 pixclk = ~pixclk;

  task automatic step();
    @(posedge pixclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_idle();
    rx_red = '0; rx_green = '0; rx_blue = '0;
    rx_hsync = 1'b0; rx_vsync = 1'b0; rx_vde = 1'b0; rx_cntrl = '0;
  endtask

  // Pixel n of the pattern (counting from release) is on tx after step n+1.
  task automatic to_pix(input int p);
    while (cyc < p + 1) step();
  endtask

  task automatic rx_line(input logic vs, input logic act, input int len, input int h0, input logic pchk);
    for (int h = h0; h < HT; h++) begin
      rx_vsync = vs;
      rx_vde   = act && (h < len);
      rx_hsync = (h >= HSS) && (h < HSE);
      rx_red   = 8'(h * 5 + 1);
      rx_green = 8'(cyc);
      rx_blue  = 8'(h) ^ 8'h5A;
      rx_cntrl = 4'(h);
      step();
      if (pchk) begin
        chk("pt_rgb", {tx_red, tx_green, tx_blue}, {rx_red, rx_green, rx_blue});
        chk("pt_sync", {tx_hsync, tx_vsync, tx_vde}, {rx_hsync, rx_vsync, rx_vde});
        chk("pt_cntrl", tx_cntrl, rx_cntrl);
      end
    end
  endtask

  task automatic vs_start();
    rx_idle();
    rx_vsync = 1'b1;
    step();
  endtask

  task automatic frame_rest(input int last_len, input logic pchk);
    rx_line(1'b1, 1'b0, 0, 1, pchk);
    rx_line(1'b1, 1'b0, 0, 0, pchk);
    rx_line(1'b0, 1'b0, 0, 0, pchk);
    for (int l = 0; l < VA; l++) rx_line(1'b0, 1'b1, (l == VA - 1) ? last_len : HA, 0, pchk);
    rx_line(1'b0, 1'b0, 0, 0, pchk);
  endtask

  initial begin
    rst = 1'b1;
    force_pattern = 1'b0;
    rx_idle();
    repeat (3) step();
    chk("rst_rgb", {tx_red, tx_green, tx_blue}, 24'h0);
    chk("rst_sync", {tx_hsync, tx_vsync, tx_vde, tx_cntrl}, 7'h0);
    chk("rst_status", {locked, src_is_rx}, 2'b00);
    chk("rst_meas", {meas_h_active, meas_v_active}, 24'h0);

    // Pattern generator from reset release
    rst = 1'b0;
    cyc = 0;
    to_pix(0);   chk("pat_h0", {tx_red, tx_green, tx_blue, tx_vde}, {24'hFFFFFF, 1'b1});
    chk("pat_h0_sync", {tx_hsync, tx_vsync, tx_cntrl}, 6'h0);
    to_pix(2);   chk("pat_yellow", {tx_red, tx_green, tx_blue}, 24'hFFFF00);
    to_pix(4);   chk("pat_cyan", {tx_red, tx_green, tx_blue}, 24'h00FFFF);
    to_pix(6);   chk("pat_green", {tx_red, tx_green, tx_blue}, 24'h00FF00);
    to_pix(8);   chk("pat_magenta", {tx_red, tx_green, tx_blue}, 24'hFF00FF);
    to_pix(10);  chk("pat_red", {tx_red, tx_green, tx_blue}, 24'hFF0000);
    to_pix(12);  chk("pat_blue", {tx_red, tx_green, tx_blue}, 24'h0000FF);
    to_pix(15);  chk("pat_black", {tx_red, tx_green, tx_blue, tx_vde}, {24'h000000, 1'b1});
    to_pix(16);  chk("pat_vde_fall", {tx_red, tx_green, tx_blue, tx_vde}, 25'h0);
    to_pix(17);  chk("pat_hs17", tx_hsync, 1'b0);
    to_pix(18);  chk("pat_hs18", tx_hsync, 1'b1);
    to_pix(19);  chk("pat_hs19", tx_hsync, 1'b1);
    to_pix(20);  chk("pat_hs20", tx_hsync, 1'b0);
    to_pix(6 * HT);      chk("pat_v6", {tx_vsync, tx_vde}, 2'b00);
    to_pix(7 * HT);      chk("pat_v7", tx_vsync, 1'b1);
    to_pix(9 * HT - 1);  chk("pat_v8_end", tx_vsync, 1'b1);
    to_pix(9 * HT);      chk("pat_v9", tx_vsync, 1'b0);
    to_pix(VT * HT);     chk("pat_wrap", {tx_red, tx_green, tx_blue, tx_vde}, {24'hFFFFFF, 1'b1});

    // Lock on a clean rx stream
    for (int f = 1; f <= 6; f++) begin
      vs_start();
      if (f == 2) chk("meas_good", {meas_h_active, meas_v_active}, {12'd16, 12'd6});
      if (f == 4) chk("lock_vs4", {locked, src_is_rx}, 2'b00);
      if (f == 5) chk("lock_vs5", {locked, src_is_rx}, 2'b10);
      if (f == 6) chk("lock_vs6", {locked, src_is_rx}, 2'b11);
      frame_rest(HA, f == 6);
    end

    // Loss of rx vsync while locked: cycle 239 since the last vs_rise edge here
    rx_idle();
    repeat (LOSS - 1 - 239) step();
    chk("loss_before", {locked, src_is_rx}, 2'b11);
    step();
    chk("loss_at", {locked, src_is_rx}, 2'b00);
    step();
    chk("loss_pat_h0", {tx_red, tx_green, tx_blue, tx_vde}, {24'hFFFFFF, 1'b1});
    step(); step();
    chk("loss_pat_h2", {tx_red, tx_green, tx_blue}, 24'hFFFF00);

    // Short line in the 3rd frame delays lock to the 8th vs_rise
    for (int f = 1; f <= 8; f++) begin
      vs_start();
      if (f == 4) begin
        chk("bad_meas_h", meas_h_active, 12'd15);
        chk("bad_meas_v", meas_v_active, 12'd6);
      end
      if (f == 5) chk("bad_vs5", {locked, meas_h_active}, {1'b0, 12'd16});
      if (f == 7) chk("bad_vs7", locked, 1'b0);
      if (f == 8) chk("bad_vs8", {locked, src_is_rx}, 2'b10);
      frame_rest((f == 3) ? HA - 1 : HA, 1'b0);
    end

    // force_pattern while locked
    vs_start();
    chk("force_pre", {locked, src_is_rx}, 2'b11);
    force_pattern = 1'b1;
    step();
    chk("force_now", {locked, src_is_rx}, 2'b10);
    step();
    chk("force_pat", {tx_red, tx_green, tx_blue, tx_vde, tx_cntrl}, {24'hFFFFFF, 1'b1, 4'h0});
    frame_rest(HA, 1'b0);
    vs_start();
    chk("force_vs_hold", {locked, src_is_rx}, 2'b10);
    force_pattern = 1'b0;
    frame_rest(HA, 1'b0);
    chk("force_rel_wait", src_is_rx, 1'b0);
    vs_start();
    chk("force_rel_vs", src_is_rx, 1'b1);

    // Single-cycle reset mid-passthrough
    rx_red = 8'hAA; rx_green = 8'hBB; rx_blue = 8'hCC;
    rx_hsync = 1'b1; rx_vsync = 1'b1; rx_vde = 1'b1; rx_cntrl = 4'h5;
    step();
    chk("pre_rst_pt", {tx_red, tx_green, tx_blue, tx_cntrl}, {24'hAABBCC, 4'h5});
    rst = 1'b1;
    step();
    chk("mid_rst_rgb", {tx_red, tx_green, tx_blue}, 24'h0);
    chk("mid_rst_sync", {tx_hsync, tx_vsync, tx_vde, tx_cntrl}, 7'h0);
    chk("mid_rst_status", {locked, src_is_rx}, 2'b00);
    chk("mid_rst_meas", {meas_h_active, meas_v_active}, 24'h0);
    rst = 1'b0;
    rx_idle();
    step();
    chk("mid_rst_pat", {tx_red, tx_green, tx_blue, tx_vde}, {24'hFFFFFF, 1'b1});
    for (int f = 1; f <= 6; f++) begin
      vs_start();
      if (f == 4) chk("relock_vs4", {locked, src_is_rx}, 2'b00);
      if (f == 5) chk("relock_vs5", {locked, src_is_rx}, 2'b10);
      if (f == 6) chk("relock_vs6", {locked, src_is_rx}, 2'b11);
      frame_rest(HA, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
